// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, fetch FSM states and instruction field widths
package cpu_pkg;

  localparam int INSTR_CMD_W  = 5;
  localparam int INSTR_OPND_W = 11;

  localparam logic [INSTR_CMD_W-1:0] NOP_CMD  = 5'd15;
  localparam logic [INSTR_CMD_W-1:0] HALT_CMD = 5'd31;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with load/increment/hold; increment wraps modulo 2^W
module pc_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] target,
  output logic [W-1:0] pc
);

  // load wins over inc; the FSM never asserts both together
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch/issue unit: PC, req/ack instruction fetch, stall and branch redirect
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CMD_W   = INSTR_CMD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic [CMD_W-1:0]         cmd,
  output logic [INSTR_W-CMD_W-1:0] operand,
  output logic                     instr_valid,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [PC_W-1:0]          branch_target,
  output logic                     halted
);

  fetch_state_t       state, next_state;
  logic [INSTR_W-1:0] ir;
  logic [CMD_W-1:0]   ir_cmd;
  logic [PC_W-1:0]    pc;
  logic               pc_inc, pc_load, ir_load;
  logic               req_q;

  assign ir_cmd = ir[INSTR_W-1 -: CMD_W];

  pc_reg #(.W(PC_W)) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (branch_target),
    .pc     (pc)
  );

  // req is registered so the cycle right after reset shows no request
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ir    <= '0;
      req_q <= 1'b0;
    end else begin
      state <= next_state;
      req_q <= (next_state == FETCH);
      if (ir_load) begin
        ir <= imem_rdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    ir_load    = 1'b0;
    case (state)
      FETCH: begin
        if (req_q && imem_ack) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (ir_cmd == CMD_W'(HALT_CMD)) begin
            next_state = HALT;
          end else if (branch_taken) begin
            pc_load    = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = FETCH;
          end
        end
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign cmd         = instr_valid ? ir_cmd : CMD_W'(NOP_CMD);
  assign operand     = instr_valid ? ir[INSTR_W-CMD_W-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven directed bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [4:0]  cmd;
  logic [10:0] operand;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halted;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_W(8), .INSTR_W(16), .CMD_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .cmd           (cmd),
    .operand       (operand),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted)
  );

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        stl;
    logic        br;
    logic [7:0]  tgt;
    logic        req;
    logic [7:0]  addr;
    logic [4:0]  cmd;
    logic [10:0] op;
    logic        valid;
    logic        halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ack, logic [15:0] rdata, logic stl, logic br,
                              logic [7:0] tgt, logic req, logic [7:0] addr, logic [4:0] c,
                              logic [10:0] op, logic valid, logic halt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.stl = stl; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.cmd = c; v.op = op; v.valid = valid; v.halt = halt;
    return v;
  endfunction

  task automatic drive(logic rst, logic ack, logic [15:0] rdata, logic stl, logic br, logic [7:0] tgt);
    reset = rst; imem_ack = ack; imem_rdata = rdata; stall = stl;
    branch_taken = br; branch_target = tgt;
  endtask

  task automatic check(string name, logic req, logic [7:0] addr, logic [4:0] c,
                       logic [10:0] op, logic valid, logic halt);
    logic [26:0] act, exp;
    act = {imem_req, imem_addr, cmd, operand, instr_valid, halted};
    exp = {req, addr, c, op, valid, halt};
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got req=%b addr=%h cmd=%0d op=%h valid=%b halted=%b, want req=%b addr=%h cmd=%0d op=%h valid=%b halted=%b",
               name, imem_req, imem_addr, cmd, operand, instr_valid, halted,
               req, addr, c, op, valid, halt);
    end
  endtask

  initial begin
    //          rst ack rdata    stl br tgt    req addr   cmd op      v  h
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 15, 11'h000, 0, 0)); // reset state
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 15, 11'h000, 0, 0)); // first fetch at 0
    vecs.push_back(mk(0, 1, 16'h1000, 0, 0, 8'h00, 0, 8'h01,  2, 11'h000, 1, 0)); // zero-wait ack
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h01, 15, 11'h000, 0, 0)); // retire -> fetch 1
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h01, 15, 11'h000, 0, 0)); // wait 1
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h01, 15, 11'h000, 0, 0)); // wait 2
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h01, 15, 11'h000, 0, 0)); // wait 3
    vecs.push_back(mk(0, 1, 16'h8ABC, 0, 0, 8'h00, 0, 8'h02, 17, 11'h2BC, 1, 0)); // late ack
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 8'h40, 0, 8'h02, 17, 11'h2BC, 1, 0)); // stall 1
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h40, 0, 8'h02, 17, 11'h2BC, 1, 0)); // stall 2
    vecs.push_back(mk(0, 1, 16'hFFFF, 1, 1, 8'h40, 0, 8'h02, 17, 11'h2BC, 1, 0)); // stall 3, stray ack
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h40, 0, 8'h02, 17, 11'h2BC, 1, 0)); // stall 4
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 8'h40, 0, 8'h02, 17, 11'h2BC, 1, 0)); // stall 5
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h40, 1, 8'h40, 15, 11'h000, 0, 0)); // branch to 0x40
    vecs.push_back(mk(0, 1, 16'h0005, 0, 0, 8'h00, 0, 8'h41,  0, 11'h005, 1, 0)); // fetch 0x40
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 8'hFF, 1, 8'hFF, 15, 11'h000, 0, 0)); // branch to 0xFF
    vecs.push_back(mk(0, 1, 16'h1234, 0, 0, 8'h00, 0, 8'h00,  2, 11'h234, 1, 0)); // pc wraps to 0
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 15, 11'h000, 0, 0)); // fetch at 0
    vecs.push_back(mk(0, 1, 16'hF801, 0, 0, 8'h00, 0, 8'h01, 31, 11'h001, 1, 0)); // HALT issued
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h40, 0, 8'h01, 15, 11'h000, 0, 1)); // halt beats branch
    vecs.push_back(mk(0, 1, 16'h1000, 0, 0, 8'h00, 0, 8'h01, 15, 11'h000, 0, 1)); // halted, ack ignored
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h22, 0, 8'h01, 15, 11'h000, 0, 1)); // still halted
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 15, 11'h000, 0, 0)); // reset leaves halt
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 15, 11'h000, 0, 0)); // restart at 0
    vecs.push_back(mk(0, 1, 16'h1000, 0, 0, 8'h00, 0, 8'h01,  2, 11'h000, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h01, 15, 11'h000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h01, 15, 11'h000, 0, 0)); // fetch wait at 1
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 15, 11'h000, 0, 0)); // reset mid-fetch
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 15, 11'h000, 0, 0)); // resumes at 0
    vecs.push_back(mk(0, 1, 16'h2000, 0, 0, 8'h00, 0, 8'h01,  4, 11'h000, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 8'h40, 0, 8'h00, 15, 11'h000, 0, 0)); // reset mid-issue
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 15, 11'h000, 0, 0)); // resumes at 0

    drive(1, 0, 16'h0, 0, 0, 8'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].stl, vecs[i].br, vecs[i].tgt);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].cmd,
            vecs[i].op, vecs[i].valid, vecs[i].halt);
    end

    // HALT held under stall does not retire, then retires and stays down
    drive(1, 0, 16'h0, 0, 0, 8'h0);
    @(posedge clk); #1;
    drive(0, 0, 16'h0, 0, 0, 8'h0);
    @(posedge clk); #1;
    drive(0, 1, 16'hF855, 0, 0, 8'h0);
    @(posedge clk); #1;
    check("halt_issue", 1'b0, 8'h01, 5'd31, 11'h055, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 16'h0, 1, 1, 8'h33);
      @(posedge clk); #1;
      check($sformatf("halt_stall%0d", k), 1'b0, 8'h01, 5'd31, 11'h055, 1'b1, 1'b0);
    end
    drive(0, 0, 16'h0, 0, 0, 8'h0);
    @(posedge clk); #1;
    check("halt_retire", 1'b0, 8'h01, 5'd15, 11'h000, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      drive(0, k[0], 16'h1000, k[1], k[2], 8'h10);
      @(posedge clk); #1;
      check($sformatf("halt_hold%0d", k), 1'b0, 8'h01, 5'd15, 11'h000, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch/issue unit sitting upstream of the main control decoder. It maintains the program counter and fetches instruction words from program memory over a req/ack handshake. Each word is held in an instruction register and presented as a `cmd` opcode field plus an operand field. The datapath controls progress through stall and branch-redirect inputs.

## Interface
Parameters:
- `PC_W`, 8: program counter / instruction memory address width
- `INSTR_W`, 16: instruction word width
- `CMD_W`, 5: opcode field width, occupying `instr[INSTR_W-1 -: CMD_W]`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request, held until ack
- `imem_addr`  out  PC_W  fetch address, equals PC while `imem_req`=1
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  fetched instruction word
- `cmd`  out  CMD_W  opcode field of instruction register, drives the decoder
- `operand`  out  INSTR_W-CMD_W  low field of instruction register
- `instr_valid`  out  1  `cmd`/`operand` hold a live instruction
- `stall`  in  1  datapath not ready; hold current instruction
- `branch_taken`  in  1  redirect PC, sampled only when an instruction retires
- `branch_target`  in  PC_W  redirect address
- `halted`  out  1  HALT opcode retired; fetch stopped

## Operation
- Registers: `pc`, instruction register `ir`, state.
- FSM states: FETCH, ISSUE, HALT.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_ack`=1: `ir`<=`imem_rdata`, `pc`<=`pc`+1 (mod 2^PC_W, so 255 wraps to 0), go to ISSUE.
  - `imem_ack`=0: stay in FETCH, request held.
- ISSUE: `instr_valid`=1, `imem_req`=0.
  - `stall`=1: hold everything; `branch_taken` is ignored.
  - `stall`=0 retires the instruction. Priority order:
    1. `cmd`==HALT_CMD: go to HALT; `branch_taken` is ignored.
    2. `branch_taken`=1: `pc`<=`branch_target`, go to FETCH.
    3. Otherwise go to FETCH with the already incremented `pc`.
- HALT: `halted`=1, `instr_valid`=0, `imem_req`=0. Only `reset` leaves this state.
- Outside ISSUE, `cmd` is forced to NOP_CMD and `operand` to 0, so the decoder always sees a NOP when `instr_valid`=0.
- `imem_ack` is ignored outside FETCH.
- Program memory shares `reset`, so no stale ack can follow reset.

## Timing
- Reset values:
  - state=FETCH, `pc`=0
  - `imem_req`=0, `imem_addr`=0
  - `cmd`=NOP_CMD (5'd15, which decodes to an all-zero control word), `operand`=0
  - `instr_valid`=0, `halted`=0
- First cycle after reset deasserts: `imem_req`=1, `imem_addr`=0.
- Zero-wait memory (ack in the same cycle as req): `instr_valid` rises one cycle after ack. Throughput is 1 instruction per 2 cycles. Each wait cycle on ack adds 1 cycle.
- All outputs are registered or decoded from state/`ir` only; there is no combinational path from inputs to outputs.
- Reset mid-FETCH or mid-ISSUE: the next cycle is the reset state and the in-flight instruction is discarded.
- Branch to the current `pc` value is legal; it simply refetches.

## Structure
- Shared package `cpu_pkg`:
  - constants NOP_CMD=5'd15 and HALT_CMD=5'd31
  - state enum `fetch_state_t`
  - field-slice localparams for the instruction format (`CMD_W`, operand width)
- One sub-module is natural: `pc_reg`, a PC register with increment/load/hold controls and wrap behaviour.
- The main decoder instantiates separately downstream; this block only drives its `cmd` input.

## Test plan
- Reset then zero-wait memory returning 0x1000 at address 0 -> `imem_addr`=0 for one cycle, then `cmd`=2, `operand`=0, `instr_valid`=1; next FETCH at addr 1.
- Memory with 3 wait cycles -> `imem_req` held with `imem_addr` stable for 4 cycles; `instr_valid` rises the cycle after ack.
- `stall`=1 for 5 cycles during ISSUE, with `branch_taken` toggling -> `cmd`/`operand` stable and no redirect; on release with `branch_taken`=1, `branch_target`=0x40 -> next `imem_addr`=0x40.
- Fetch at pc=0xFF with no branch -> next `imem_addr`=0x00.
- Instruction with `cmd`=31 retires while `branch_taken`=1 -> `halted`=1, `imem_req` stays 0 indefinitely, `cmd`=15; `reset` -> fetch restarts at 0.
- Assert `reset` during a FETCH wait -> the following cycle has `imem_req`=0 and `instr_valid`=0; after release, fetch resumes at addr 0.
